// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and encodings for the data-memory arbiter:
//               FSM state type and the {MemRead,MemWrite} control encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    // Bit positions inside the two-bit memory control word.
    localparam int MEM_RD_BIT = 1;
    localparam int MEM_WR_BIT = 0;

    localparam logic [1:0] CTRL_NONE = 2'b00;
    localparam logic [1:0] CTRL_WR   = 2'b01;
    localparam logic [1:0] CTRL_RD   = 2'b10;

    // Exactly one of read/write is ever asserted, so 2'b11 cannot be produced.
    function automatic logic [1:0] ctrl_for(input logic is_write);
        logic [1:0] ctrl;
        ctrl = CTRL_NONE;
        if (is_write) begin
            ctrl = CTRL_WR;
        end else begin
            ctrl = CTRL_RD;
        end
        return ctrl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Scans the request vector
//               starting at the pointer and returns the first requester found
//               as a one-hot grant plus its index.
//               Optional macro MEM_ARB_PRIO0_EN: requester 0 wins outright
//               whenever it requests; the rest are round-robin among
//               themselves (index 0 is never chosen by the scan).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_any
);

    // One extra bit so pointer+offset cannot overflow before the wrap.
    localparam int PW1 = PTR_W + 1;

    logic [NUM_REQ-1:0] w_req_m;
    logic [PW1-1:0]     w_pos;

    // Scan from the pointer, first requesting index wins.
    always_comb begin
        w_req_m = i_req;
        o_gnt   = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_pos   = '0;
`ifdef MEM_ARB_PRIO0_EN
        if (i_req[0]) begin
            o_gnt[0] = 1'b1;
            o_any    = 1'b1;
        end
        w_req_m[0] = 1'b0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            w_pos = {1'b0, i_ptr} + PW1'(k);
            if (w_pos >= PW1'(NUM_REQ)) begin
                w_pos = w_pos - PW1'(NUM_REQ);
            end
            if (!o_any && w_req_m[w_pos[PTR_W-1:0]]) begin
                o_any                    = 1'b1;
                o_gnt[w_pos[PTR_W-1:0]]  = 1'b1;
                o_idx                    = w_pos[PTR_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares the single-port data memory between NUM_REQ
//               requesters. Each transaction: arbitrate and latch in IDLE,
//               one ISSUE cycle driving the memory, and for reads one RESP
//               cycle returning the captured data.
//               Optional macro MEM_ARB_PRIO0_EN gives requester 0 fixed
//               priority over the round-robin group.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [NUM_REQ-1:0]        i_we,
    input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
    output logic [NUM_REQ-1:0]        o_gnt,
    output logic [NUM_REQ-1:0]        o_rvalid,
    output logic [DATA_W-1:0]         o_rdata,
    output logic [1:0]                o_mem_ctrl,
    output logic [ADDR_W-1:0]         o_mem_addr,
    output logic [DATA_W-1:0]         o_mem_wdata,
    input  logic [DATA_W-1:0]         i_mem_rdata
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t           r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [PTR_W-1:0]     r_win;
    logic [NUM_REQ-1:0]   r_win_oh;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata;

    logic [NUM_REQ-1:0]   w_pick_oh;
    logic [PTR_W-1:0]     w_pick_idx;
    logic                 w_pick_any;
    logic [PTR_W-1:0]     w_ptr_inc;
    logic [PTR_W-1:0]     w_ptr_next;
    logic [1:0]           w_mem_ctrl;

    logic [ADDR_W-1:0]    w_addr_arr  [NUM_REQ];
    logic [DATA_W-1:0]    w_wdata_arr [NUM_REQ];

    // Split the flat per-requester buses into indexable arrays.
    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
            assign w_addr_arr[g]  = i_addr[g*ADDR_W +: ADDR_W];
            assign w_wdata_arr[g] = i_wdata[g*DATA_W +: DATA_W];
        end
    endgenerate

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_picker (
        .i_req (i_req),
        .i_ptr (r_ptr),
        .o_gnt (w_pick_oh),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    // Pointer moves just past the winner; with fixed priority, wins by
    // requester 0 leave the round-robin position untouched.
    always_comb begin
        w_ptr_inc = (r_win == PTR_W'(NUM_REQ - 1)) ? '0 : r_win + PTR_W'(1);
`ifdef MEM_ARB_PRIO0_EN
        w_ptr_next = (r_win == '0) ? r_ptr : w_ptr_inc;
`else
        w_ptr_next = w_ptr_inc;
`endif
    end

    // Memory control is only active during the single issue cycle.
    always_comb begin
        w_mem_ctrl = CTRL_NONE;
        if (r_state == ISSUE) begin
            w_mem_ctrl = ctrl_for(r_we);
        end
    end

    // Transaction sequencer: latch in IDLE, drive memory in ISSUE, return in RESP.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_win    <= '0;
            r_win_oh <= '0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_win    <= w_pick_idx;
                        r_win_oh <= w_pick_oh;
                        r_we     <= i_we[w_pick_idx];
                        r_addr   <= w_addr_arr[w_pick_idx];
                        r_wdata  <= w_wdata_arr[w_pick_idx];
                        r_state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_ptr <= w_ptr_next;
                    if (w_mem_ctrl[MEM_RD_BIT]) begin
                        r_rdata <= i_mem_rdata;
                        r_state <= RESP;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Grant and read-valid are the latched winner gated by the phase.
    always_comb begin
        o_gnt    = (r_state == ISSUE) ? r_win_oh : '0;
        o_rvalid = (r_state == RESP)  ? r_win_oh : '0;
    end

    assign o_mem_ctrl  = w_mem_ctrl;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_rdata     = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter: directed scenarios plus
//               a randomized run against a transaction-level reference model
//               with a shadow memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [NR-1:0]  req;
    logic [NR-1:0]  we;
    logic [NR*AW-1:0] addr;
    logic [NR*DW-1:0] wdata;
    logic [NR-1:0]  gnt;
    logic [NR-1:0]  rvalid;
    logic [DW-1:0]  rdata;
    logic [1:0]     mem_ctrl;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    bit [DW-1:0] mem  [0:2047];
    bit [DW-1:0] smem [0:2047];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_req       (req),
        .i_we        (we),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_gnt       (gnt),
        .o_rvalid    (rvalid),
        .o_rdata     (rdata),
        .o_mem_ctrl  (mem_ctrl),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .i_mem_rdata (mem_rdata)
    );

    // Single-port word memory behind the arbiter.
    always_ff @(posedge clk) begin
        if (mem_ctrl == 2'b01) mem[mem_addr[12:2]] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr[12:2]];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
        req[r]           = 1'b1;
        we[r]            = w;
        addr[r*AW +: AW] = a;
        wdata[r*DW +: DW] = d;
    endtask

    task automatic do_reset;
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Arbitration rule from the description, expressed over plain integers.
    function automatic int pick(input logic [NR-1:0] r, input int p);
`ifdef MEM_ARB_PRIO0_EN
        if (r[0]) return 0;
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (p + k) % NR;
            if (j != 0 && r[j]) return j;
        end
`else
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (p + k) % NR;
            if (r[j]) return j;
        end
`endif
        return -1;
    endfunction

    task automatic test_reset;
        do_reset;
        n_tests++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL rst_gnt: got %b want 00", gnt); end
        n_tests++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid: got %b want 00", rvalid); end
        n_tests++; if (mem_ctrl !== 2'b00) begin n_fail++; $display("FAIL rst_ctrl: got %b want 00", mem_ctrl); end
        n_tests++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", mem_addr); end
        n_tests++; if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        n_tests++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", rdata); end
        // Start a read, then reset in the middle of it.
        set_req(0, 1'b0, 32'h20, 32'h0);
        tick;
        n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL rstmid_gnt: got %b want 01", gnt); end
        rst = 1'b1; req = '0;
        tick;
        tick;
        n_tests++; if (gnt !== 2'b00 || rvalid !== 2'b00) begin n_fail++; $display("FAIL rstmid_pulses: got gnt %b rvalid %b want 00/00", gnt, rvalid); end
        n_tests++; if (mem_ctrl !== 2'b00 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_outs: got ctrl %b addr %h wdata %h rdata %h want zeros", mem_ctrl, mem_addr, mem_wdata, rdata);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            n_tests++; if (rvalid !== 2'b00 || gnt !== 2'b00) begin n_fail++; $display("FAIL rstmid_after: got gnt %b rvalid %b want 00/00", gnt, rvalid); end
        end
        // Arbiter must be back in IDLE: a fresh request is granted next cycle.
        set_req(1, 1'b1, 32'h40, 32'h1234);
        tick;
        n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL rst_idle_gnt: got %b want 10", gnt); end
        req = '0;
        tick;
    endtask

    task automatic test_single_write;
        do_reset;
        set_req(1, 1'b1, 32'h10, 32'hDEADBEEF);
        tick;
        n_tests++; if (gnt !== 2'b10) begin n_fail++; $display("FAIL wr_gnt: got %b want 10", gnt); end
        n_tests++; if (mem_ctrl !== 2'b01) begin n_fail++; $display("FAIL wr_ctrl: got %b want 01", mem_ctrl); end
        n_tests++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL wr_addr: got %h want 10", mem_addr); end
        n_tests++; if (mem_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_wdata: got %h want deadbeef", mem_wdata); end
        req = '0;
        tick;
        n_tests++; if (gnt !== 2'b00 || mem_ctrl !== 2'b00 || rvalid !== 2'b00) begin
            n_fail++; $display("FAIL wr_done: got gnt %b ctrl %b rvalid %b want 00/00/00", gnt, mem_ctrl, rvalid);
        end
        n_tests++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL wr_addr_hold: got %h want 10", mem_addr); end
        set_req(1, 1'b0, 32'h10, 32'h0);
        tick;
        n_tests++; if (gnt !== 2'b10 || mem_ctrl !== 2'b10) begin n_fail++; $display("FAIL rd_issue: got gnt %b ctrl %b want 10/10", gnt, mem_ctrl); end
        req = '0;
        tick;
        n_tests++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL rd_rvalid: got %b want 10", rvalid); end
        n_tests++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h want deadbeef", rdata); end
        n_tests++; if (mem_ctrl !== 2'b00) begin n_fail++; $display("FAIL rd_resp_ctrl: got %b want 00", mem_ctrl); end
        tick;
        n_tests++; if (rvalid !== 2'b00 || rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_hold: got rvalid %b rdata %h want 00/deadbeef", rvalid, rdata); end
    endtask

    task automatic test_alternate;
        logic [1:0] exp_g;
        logic [1:0] exp_v;
        logic [1:0] last_g;
        do_reset;
        set_req(0, 1'b0, 32'h100, 32'h0);
        set_req(1, 1'b0, 32'h200, 32'h0);
        last_g = 2'b00;
        for (int c = 0; c < 12; c++) begin
            tick;
            exp_g = 2'b00;
            if (c % 3 == 0) begin
`ifdef MEM_ARB_PRIO0_EN
                exp_g = 2'b01;
`else
                exp_g = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
`endif
            end
            exp_v = (c % 3 == 1) ? last_g : 2'b00;
            n_tests++; if (gnt !== exp_g) begin n_fail++; $display("FAIL alt_gnt c%0d: got %b want %b", c, gnt, exp_g); end
            n_tests++; if (rvalid !== exp_v) begin n_fail++; $display("FAIL alt_rvalid c%0d: got %b want %b", c, rvalid, exp_v); end
            if (c % 3 == 0) last_g = exp_g;
        end
        req = '0;
        tick;
        tick;
    endtask

    task automatic test_prio;
        logic [1:0] exp_g;
        do_reset;
        set_req(0, 1'b0, 32'h300, 32'h0);
        set_req(1, 1'b0, 32'h304, 32'h0);
        for (int c = 0; c < 12; c++) begin
            tick;
            exp_g = 2'b00;
            if (c % 3 == 0) begin
`ifdef MEM_ARB_PRIO0_EN
                exp_g = (c < 9) ? 2'b01 : 2'b10;
`else
                exp_g = ((c / 3) % 2 == 0) ? 2'b01 : 2'b10;
`endif
            end
            n_tests++; if (gnt !== exp_g) begin n_fail++; $display("FAIL prio_gnt c%0d: got %b want %b", c, gnt, exp_g); end
            if (c == 6) req[0] = 1'b0;
        end
        req = '0;
        tick;
        tick;
    endtask

    task automatic test_rw_boundary;
        int ng;
        int nv;
        logic [31:0] exp_rd;
        do_reset;
        ng = 0; nv = 0;
        exp_rd = mem[11'h7FF];
        set_req(0, 1'b0, 32'h7FFC, 32'h0);
        for (int c = 0; c < 8; c++) begin
            tick;
            n_tests++; if (mem_ctrl === 2'b11) begin n_fail++; $display("FAIL rw_ctrl11 c%0d: got %b want not 11", c, mem_ctrl); end
            if (gnt[0]) begin
                n_tests++; if (mem_addr !== 32'h7FFC) begin n_fail++; $display("FAIL rw_addr: got %h want 7ffc", mem_addr); end
                n_tests++; if (mem_ctrl !== ((ng == 0) ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL rw_kind: got %b want %b", mem_ctrl, (ng == 0) ? 2'b10 : 2'b01); end
                ng++;
                if (ng == 1) set_req(0, 1'b1, 32'h7FFC, 32'hA5A55A5A);
                else req = '0;
            end
            if (rvalid != 2'b00) begin
                nv++;
                n_tests++; if (rvalid !== 2'b01 || rdata !== exp_rd) begin n_fail++; $display("FAIL rw_rvalid: got %b/%h want 01/%h", rvalid, rdata, exp_rd); end
            end
        end
        n_tests++; if (ng != 2) begin n_fail++; $display("FAIL rw_ngnt: got %0d want 2", ng); end
        n_tests++; if (nv != 1) begin n_fail++; $display("FAIL rw_nrvalid: got %0d want 1", nv); end
        n_tests++; if (mem[11'h7FF] !== 32'hA5A55A5A) begin n_fail++; $display("FAIL rw_memword: got %h want a5a55a5a", mem[11'h7FF]); end
    endtask

    task automatic test_drop_after_latch;
        do_reset;
        set_req(0, 1'b1, 32'h44, 32'hCAFEF00D);
        tick;
        req = '0;
        n_tests++; if (gnt !== 2'b01) begin n_fail++; $display("FAIL drop_gnt: got %b want 01", gnt); end
        n_tests++; if (mem_ctrl !== 2'b01 || mem_wdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL drop_issue: got %b/%h want 01/cafef00d", mem_ctrl, mem_wdata); end
        tick;
        n_tests++; if (mem[11'h011] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL drop_memword: got %h want cafef00d", mem[11'h011]); end
        for (int i = 0; i < 2; i++) begin
            tick;
            n_tests++; if (gnt !== 2'b00 || rvalid !== 2'b00) begin n_fail++; $display("FAIL drop_quiet: got %b/%b want 00/00", gnt, rvalid); end
        end
    endtask

    task automatic test_random;
        logic [NR-1:0]    s_req;
        logic [NR-1:0]    s_we;
        logic [NR*AW-1:0] s_addr;
        logic [NR*DW-1:0] s_wdata;
        logic [1:0]  e_gnt, e_rv, e_ctrl;
        logic [31:0] m_addr, m_wdata, m_rdata, rv_data;
        int m_ptr, next_sample, rv_due, rv_who, w;
        do_reset;
        smem = mem;
        m_ptr = 0; next_sample = 0; rv_due = -1; rv_who = 0;
        m_addr = '0; m_wdata = '0; m_rdata = '0; rv_data = '0;
        for (int c = 0; c < 600; c++) begin
            s_req = req; s_we = we; s_addr = addr; s_wdata = wdata;
            tick;
            e_gnt = '0; e_rv = '0; e_ctrl = 2'b00;
            if (rv_due == c) begin
                e_rv[rv_who] = 1'b1;
                m_rdata = rv_data;
            end
            if (c >= next_sample && s_req != '0) begin
                w = pick(s_req, m_ptr);
                e_gnt[w] = 1'b1;
                m_addr  = s_addr[w*AW +: AW];
                m_wdata = s_wdata[w*DW +: DW];
                if (s_we[w]) begin
                    e_ctrl = 2'b01;
                    smem[m_addr[12:2]] = m_wdata;
                    next_sample = c + 2;
                end else begin
                    e_ctrl = 2'b10;
                    rv_due = c + 1; rv_who = w; rv_data = smem[m_addr[12:2]];
                    next_sample = c + 3;
                end
`ifdef MEM_ARB_PRIO0_EN
                if (w != 0) m_ptr = (w + 1) % NR;
`else
                m_ptr = (w + 1) % NR;
`endif
            end
            n_tests++; if (gnt !== e_gnt) begin n_fail++; $display("FAIL rnd_gnt c%0d: got %b want %b", c, gnt, e_gnt); end
            n_tests++; if (rvalid !== e_rv) begin n_fail++; $display("FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid, e_rv); end
            n_tests++; if (mem_ctrl !== e_ctrl) begin n_fail++; $display("FAIL rnd_ctrl c%0d: got %b want %b", c, mem_ctrl, e_ctrl); end
            n_tests++; if (mem_addr !== m_addr) begin n_fail++; $display("FAIL rnd_addr c%0d: got %h want %h", c, mem_addr, m_addr); end
            n_tests++; if (mem_wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, mem_wdata, m_wdata); end
            n_tests++; if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata c%0d: got %h want %h", c, rdata, m_rdata); end
            // Requester agents: hold until granted, then drop or re-request.
            for (int r = 0; r < NR; r++) begin
                if (req[r] && gnt[r]) begin
                    if ($urandom_range(0, 1) == 1)
                        set_req(r, 1'($urandom_range(0, 1)), $urandom() & 32'h0000_603F, $urandom());
                    else
                        req[r] = 1'b0;
                end else if (!req[r] && $urandom_range(0, 2) == 0) begin
                    set_req(r, 1'($urandom_range(0, 1)), $urandom() & 32'h0000_603F, $urandom());
                end
            end
        end
        req = '0;
        tick;
        tick;
        tick;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
        test_reset;
        test_single_write;
        test_alternate;
        test_prio;
        test_rw_boundary;
        test_drop_after_latch;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
